// File: rtl/ps2_key_tx.sv
// ps2_key_tx: device-side PS/2 keyboard transmitter fed by MiSTer ps2_key event words.
// Define PS2_TX_INHIBIT_EN to add ps2_clk_in and abort/restart a frame on host inhibit.
module ps2_key_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int PS2_HZ     = 12500,
    parameter int GAP_HALVES = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
`ifdef PS2_TX_INHIBIT_EN
    input  logic        ps2_clk_in,
`endif
    output logic        ps2_clk_out,
    output logic        ps2_dat_out,
    output logic        busy,
    output logic        overflow
);
    localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
    localparam int GAP_CYC = GAP_HALVES * HALF;
    localparam int CMAX    = GAP_CYC > HALF ? GAP_CYC : HALF;
    localparam int CW      = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, LOAD, BIT_HI, BIT_LO, GAP
`ifdef PS2_TX_INHIBIT_EN
        , INHIBIT
`endif
    } state_t;

    state_t        state, nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   fill, free;
    logic          armed, prev_tog, event_v, push, pop;
    logic [1:0]    need;
    logic [7:0]    b0, b1, b2;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [10:0]   shift;
    logic          half_done, gap_done, hold_cnt;

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] clk_meta;
    logic       clk_sync;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) clk_meta <= 2'b11;
        else clk_meta <= {clk_meta[0], ps2_clk_in};
    end
    assign clk_sync = clk_meta[1];
    // The inhibit release timer only runs while the bus clock stays high.
    assign hold_cnt = state == INHIBIT && !clk_sync;
`else
    assign hold_cnt = 1'b0;
`endif

    assign half_done = cnt == CW'(HALF - 1);
    assign gap_done  = cnt == CW'(GAP_CYC - 1);
    assign busy      = fill != '0 || state != IDLE;

    // Prefix bytes go first; a whole event is accepted or dropped as one unit.
    always_comb begin
        event_v = armed && ps2_key[10] != prev_tog;
        need    = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
        b0      = ps2_key[8] ? 8'hE0 : !ps2_key[9] ? 8'hF0 : ps2_key[7:0];
        b1      = ps2_key[8] && !ps2_key[9] ? 8'hF0 : ps2_key[7:0];
        b2      = ps2_key[7:0];
        free    = (AW+1)'(FIFO_DEPTH) - fill;
        push    = event_v && free >= (AW+1)'(need);
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wp] <= b0;
            if (need > 2'd1) mem[wp + AW'(1)] <= b1;
            if (need > 2'd2) mem[wp + AW'(2)] <= b2;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            prev_tog <= 1'b0;
            overflow <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            fill     <= '0;
        end else begin
            armed    <= 1'b1;
            prev_tog <= ps2_key[10];
            overflow <= event_v && !push;
            if (push) wp <= wp + AW'(need);
            if (pop) rp <= rp + AW'(1);
            fill <= fill + (push ? (AW+1)'(need) : '0) - (AW+1)'(pop);
        end
    end

    always_comb begin
        nxt         = state;
        pop         = 1'b0;
        ps2_clk_out = 1'b1;
        ps2_dat_out = 1'b1;
        case (state)
            IDLE: nxt = fill != '0 ? LOAD : IDLE;
            LOAD: begin
                pop = 1'b1;
                nxt = BIT_HI;
            end
            BIT_HI: begin
                ps2_dat_out = shift[idx];
                nxt         = half_done ? BIT_LO : BIT_HI;
`ifdef PS2_TX_INHIBIT_EN
                if (!clk_sync && idx < 4'd10) nxt = INHIBIT;
`endif
            end
            BIT_LO: begin
                ps2_clk_out = 1'b0;
                ps2_dat_out = shift[idx];
                nxt         = !half_done ? BIT_LO : idx == 4'd10 ? GAP : BIT_HI;
            end
            GAP: nxt = gap_done ? IDLE : GAP;
`ifdef PS2_TX_INHIBIT_EN
            INHIBIT: nxt = clk_sync && half_done ? BIT_HI : INHIBIT;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '1;
        end else begin
            state <= nxt;
            cnt   <= nxt != state || hold_cnt ? '0 : cnt + CW'(1);
            if (state == LOAD) shift <= {1'b1, ~^mem[rp], mem[rp], 1'b0};
            if (state == LOAD || (state != BIT_HI && nxt == BIT_HI && state != BIT_LO)) idx <= '0;
            else if (state == BIT_LO && nxt == BIT_HI) idx <= idx + 4'd1;
        end
    end
endmodule

// File: doc/ps2_key_tx.md
Name: ps2_key_tx

Overview:
- Device-side PS/2 keyboard transmitter. Converts MiSTer-style `ps2_key` event words into a serial PS/2 clock/data stream.
- Its outputs drive the core's `PS2_CLK`/`PS2_DAT` inputs. It is the transmit end of the PS/2 link whose receiver lives inside the rememotech core.
- Queues prefix bytes (E0 extended, F0 break), frames each byte (start, 8 data LSB first, odd parity, stop) and paces the bits at PS/2 rate from `clk_sys`.

Parameters:
- CLK_HZ, 50000000, frequency of `clk_sys` in Hz.
- PS2_HZ, 12500, PS/2 bit-clock rate in Hz. HALF = CLK_HZ/(2*PS2_HZ) `clk_sys` cycles per half bit (2000 at defaults). Must be ≥ 2.
- GAP_HALVES, 8, idle half-periods inserted after each frame's stop bit.
- FIFO_DEPTH, 8, byte queue depth (power of 2, ≥ 4).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle (event on change), [9] pressed, [8] extended, [7:0] scancode.
- ps2_clk_out  out  1  PS/2 clock, idle high.
- ps2_dat_out  out  1  PS/2 data, idle high.
- busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE.
- overflow  out  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset values:
  - `ps2_clk_out` = 1, `ps2_dat_out` = 1, `busy` = 0, `overflow` = 0.
  - FIFO empty, FSM IDLE, `armed` = 0, `prev_tog` = 0.
- Event capture:
  - First cycle after reset release: `prev_tog` <= ps2_key[10], `armed` <= 1, nothing is pushed.
  - Afterwards, ps2_key[10] != prev_tog marks an event; `prev_tog` updates the same cycle.
  - Bytes needed N = [8] + (~[9]) + 1. Push order in one cycle: E0 if [8], then F0 if ~[9], then [7:0].
  - If free slots < N: push nothing, pulse `overflow` for 1 cycle. An event is never split.
  - A push and a pop in the same cycle are both honoured. Free-slot count is taken before that cycle's pop.
- FSM states IDLE, LOAD, BIT_HI, BIT_LO, GAP:
  - IDLE: if FIFO non-empty, go to LOAD. Both lines are high.
  - LOAD (1 cycle): pop byte, build shift = {1, ^~byte, byte, 0} (11 bits, start first). Set bit index = 0.
  - BIT_HI: `ps2_dat_out` = shift[idx]; `ps2_clk_out` = 1 for HALF cycles, then go to BIT_LO. Data changes only at BIT_HI entry.
  - BIT_LO: `ps2_clk_out` = 0 for HALF cycles; data held.
    - If idx == 10, go to GAP.
    - Otherwise idx++ and return to BIT_HI.
  - GAP: both lines high for GAP_HALVES*HALF cycles, then go to IDLE.
- Frame timing:
  - One frame = 22*HALF cycles plus gap. Receiver samples on the falling edge of `ps2_clk_out`.
  - First falling edge comes HALF cycles after LOAD.
- Parity is odd: the parity bit makes the total count of ones in data+parity odd.
- Half-period counter width: clog2(max(HALF, GAP_HALVES*HALF)).
- Reset asserted mid-frame: lines return high asynchronously and the FIFO clears. The partial frame is abandoned and not retransmitted.

Optional Feature:
- Macro: PS2_TX_INHIBIT_EN.
- When defined:
  - Adds input `ps2_clk_in` (1 bit, the sensed bus clock, synchronised internally through 2 flops).
  - In BIT_HI, if synced `ps2_clk_in` == 0 (host inhibit), abort to an INHIBIT state. Both outputs high; the current byte is retained.
  - When the synced clock has been high for HALF cycles, restart the same byte from the start bit.
  - An abort after bit index 9 does not retransmit; the frame completes.
- When undefined: no `ps2_clk_in` port, no INHIBIT state, the bus is never sensed.

Test Plan:
- Defaults; toggle event with [9]=1, [8]=0, code 0x1C -> one frame. Data sampled at the 11 falling edges = 0,0,0,1,1,1,0,0,0,0,1. Falling edges are 4000 cycles apart. `busy` falls 2000*(22+8)+1 cycles after LOAD.
- Event [9]=0, [8]=1, code 0x75 -> three frames in order E0 (parity 0), F0 (parity 1), 75 (parity 0). Each frame is followed by a 16000-cycle idle-high gap.
- Three extended-release events on consecutive cycles, FIFO_DEPTH=8 -> first two queued (6 bytes). Third dropped with a single-cycle `overflow` pulse. Exactly 6 frames emitted.
- ps2_key[10] different from 0 at reset release -> no frame emitted. A later toggle emits exactly one event.
- reset_n low at bit index 5 of a frame -> `ps2_clk_out`/`ps2_dat_out` high in the same cycle, `busy` = 0. After release with no new event, the lines stay idle for 100000 cycles.
- PS2_TX_INHIBIT_EN: drive `ps2_clk_in` low during BIT_HI of bit 3 of 0x1C, release after 5000 cycles -> line held high. Full 0x1C frame restarts from the start bit 2000 cycles after the synced release.
